// File: rtl/multi_seq_det_pkg.sv
// rtl/multi_seq_det_pkg.sv - width helpers shared by multi_seq_det and its lanes
package multi_seq_det_pkg;

  // Index width for n entries; a single entry still needs a 1-bit port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold 0..n inclusive.
  function automatic int fill_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/multi_seq_det_defs.vh
// rtl/multi_seq_det_defs.vh - default parameter values for multi_seq_det
`ifndef MULTI_SEQ_DET_DEFS_VH
`define MULTI_SEQ_DET_DEFS_VH

`define MSD_NUM_PAT  2
`define MSD_PAT_LEN  4
`define MSD_CNT_W    8
// Pattern i occupies bits [i*PAT_LEN +: PAT_LEN]: pattern0 = 0110, pattern1 = 0111.
`define MSD_PAT_INIT {4'b0111, 4'b0110}

`endif

// File: rtl/seq_match_lane.sv
// rtl/seq_match_lane.sv - one pattern: register, fill counter, compare, pulse, match counter
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   din_valid         a new bit is being sampled this edge
//   window            {history[PAT_LEN-2:0], din}, the candidate PAT_LEN-bit window
//   overlap_en        1 = keep fill full after a match, 0 = restart from empty
//   cfg_we/idx/pat    pattern write; only acts when cfg_idx equals LANE_IDX
//   clear_cnt         synchronous clear of the match counter
//   detected          registered one-cycle match pulse
//   match_cnt         saturating count of matches
module seq_match_lane
  import multi_seq_det_pkg::*;
#(
  parameter int                 PAT_LEN  = 4,
  parameter int                 CNT_W    = 8,
  parameter int                 IDX_W    = 1,
  parameter int                 LANE_IDX = 0,
  parameter logic [PAT_LEN-1:0] PAT_RST  = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din_valid,
  input  logic [PAT_LEN-1:0] window,
  input  logic               overlap_en,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [PAT_LEN-1:0] cfg_pat,
  input  logic               clear_cnt,
  output logic               detected,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int                FILL_W    = fill_w(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_LEN - 1);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [IDX_W-1:0]  MY_IDX    = IDX_W'(LANE_IDX);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  logic [PAT_LEN-1:0] r_pat;
  logic [FILL_W-1:0]  r_fill;
  logic               r_det;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_sel;
  logic               w_hit;
  logic [FILL_W-1:0]  w_fill_nxt;

  always_comb begin
    w_sel      = cfg_we && (cfg_idx == MY_IDX);
    // The completing bit counts toward fill, so fill only needs PAT_LEN-1 here.
    // Compare uses the pattern before any same-edge write.
    w_hit      = din_valid && (r_fill >= FILL_ARM) && (window == r_pat);
    w_fill_nxt = r_fill;
    if (w_sel) begin
      w_fill_nxt = '0;
    end else if (din_valid) begin
      if (w_hit) begin
        w_fill_nxt = overlap_en ? FILL_FULL : '0;
      end else if (r_fill != FILL_FULL) begin
        w_fill_nxt = r_fill + FILL_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pat  <= PAT_RST;
      r_fill <= '0;
      r_det  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_det  <= w_hit;
      r_fill <= w_fill_nxt;
      if (w_sel) begin
        r_pat <= cfg_pat;
      end
      // A match on the clearing edge survives as a count of one.
      if (clear_cnt) begin
        r_cnt <= w_hit ? CNT_ONE : '0;
      end else if (w_hit && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  assign detected  = r_det;
  assign match_cnt = r_cnt;

endmodule

// File: rtl/multi_seq_det.sv
// rtl/multi_seq_det.sv - serial multi-pattern sequence detector with per-pattern counters
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   din_valid, din    serial input bit and its qualifier
//   overlap_en        1 = overlapping matches, 0 = non-overlapping
//   cfg_we/idx/pat    runtime pattern write (out-of-range index ignored)
//   clear_cnt         synchronous clear of every match counter
//   detected          per-pattern one-cycle match pulse
//   match_cnt         per-pattern saturating counts, pattern i in [i*CNT_W +: CNT_W]
`include "multi_seq_det_defs.vh"

module multi_seq_det
  import multi_seq_det_pkg::*;
#(
  parameter int                         NUM_PAT  = `MSD_NUM_PAT,
  parameter int                         PAT_LEN  = `MSD_PAT_LEN,
  parameter int                         CNT_W    = `MSD_CNT_W,
  parameter logic [NUM_PAT*PAT_LEN-1:0] PAT_INIT = `MSD_PAT_INIT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       din_valid,
  input  logic                       din,
  input  logic                       overlap_en,
  input  logic                       cfg_we,
  input  logic [idx_w(NUM_PAT)-1:0]  cfg_idx,
  input  logic [PAT_LEN-1:0]         cfg_pat,
  input  logic                       clear_cnt,
  output logic [NUM_PAT-1:0]         detected,
  output logic [NUM_PAT*CNT_W-1:0]   match_cnt
);

  localparam int IDX_W = idx_w(NUM_PAT);

  // Oldest bit ends up in the MSB so windows line up with pattern MSB-first order.
  logic [PAT_LEN-1:0] r_hist;
  logic [PAT_LEN-1:0] w_window;

  assign w_window = {r_hist[PAT_LEN-2:0], din};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist <= '0;
    end else if (din_valid) begin
      r_hist <= w_window;
    end
  end

  for (genvar i = 0; i < NUM_PAT; i++) begin : g_lane
    seq_match_lane #(
      .PAT_LEN  (PAT_LEN),
      .CNT_W    (CNT_W),
      .IDX_W    (IDX_W),
      .LANE_IDX (i),
      .PAT_RST  (PAT_INIT[i*PAT_LEN +: PAT_LEN])
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .din_valid  (din_valid),
      .window     (w_window),
      .overlap_en (overlap_en),
      .cfg_we     (cfg_we),
      .cfg_idx    (cfg_idx),
      .cfg_pat    (cfg_pat),
      .clear_cnt  (clear_cnt),
      .detected   (detected[i]),
      .match_cnt  (match_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: doc/multi_seq_det.md
MULTI_SEQ_DET -- requirements
Module: multi_seq_det

Interface
REQ-001 SHALL have parameter NUM_PAT, default 2, number of independently detected patterns (1..8).
REQ-002 SHALL have parameter PAT_LEN, default 4, pattern length in bits (2..16).
REQ-003 SHALL have parameter CNT_W, default 8, width of each per-pattern match counter.
REQ-004 SHALL have parameter PAT_INIT, default {4'b0111, 4'b0110}, NUM_PAT*PAT_LEN reset patterns, pattern i in bits [i*PAT_LEN +: PAT_LEN].
REQ-005 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port: din_valid  input  1  din is sampled this cycle.
REQ-008 SHALL have port: din  input  1  serial data bit.
REQ-009 SHALL have port: overlap_en  input  1  1 = overlapping matches allowed, 0 = non-overlapping.
REQ-010 SHALL have port: cfg_we  input  1  pattern write strobe.
REQ-011 SHALL have port: cfg_idx  input  $clog2(NUM_PAT) (min 1)  pattern index to write.
REQ-012 SHALL have port: cfg_pat  input  PAT_LEN  new pattern value.
REQ-013 SHALL have port: clear_cnt  input  1  synchronous clear of all match counters.
REQ-014 SHALL have port: detected  output  NUM_PAT  per-pattern one-cycle match pulse.
REQ-015 SHALL have port: match_cnt  output  NUM_PAT*CNT_W  per-pattern saturating match counts, pattern i in [i*CNT_W +: CNT_W].

Function
REQ-016 Bit order SHALL be: first-received bit compares against pattern MSB, last-received bit against LSB.
REQ-017 A shared PAT_LEN-bit history register SHALL shift in din on every clock edge with din_valid=1 and hold otherwise.
REQ-018 Each pattern SHALL keep a fill counter (0..PAT_LEN) of valid bits eligible for its next match; it increments per valid bit, saturating at PAT_LEN.
REQ-019 Pattern i SHALL match on a valid edge when fill_i+1 >= PAT_LEN and {history[PAT_LEN-2:0], din} equals pattern i.
REQ-020 detected[i] SHALL be registered: high for exactly the one cycle following the edge sampling the completing bit; low otherwise.
REQ-021 On a match with overlap_en=1, fill_i SHALL stay at PAT_LEN; with overlap_en=0, fill_i SHALL reset to 0 (next match needs PAT_LEN fresh bits).
REQ-022 Multiple patterns SHALL be able to match on the same bit; each asserts its own detected bit.
REQ-023 match_cnt[i] SHALL increment on the edge that registers detected[i], saturating at 2^CNT_W-1.
REQ-024 clear_cnt SHALL zero all counters; a match coinciding with clear_cnt SHALL leave that counter at 1.
REQ-025 cfg_we SHALL write cfg_pat into pattern cfg_idx at the edge and clear fill_cfg_idx to 0; a valid bit on that same edge SHALL compare against the old pattern and its match still reports.
REQ-026 cfg_idx >= NUM_PAT SHALL be ignored.
REQ-027 overlap_en SHALL be sampled per edge; changing it mid-stream affects only matches from that edge on.

Reset
REQ-028 While reset=0: history=0, all fill counters=0, detected=0, match_cnt=0, patterns=PAT_INIT, asynchronously.
REQ-029 Reset assertion mid-sequence SHALL discard partial history; reset release SHALL be followed by a synchronous first edge.

Structure
REQ-030 Default parameter values and the PAT_INIT default SHALL live in a shared header multi_seq_det_defs.vh.
REQ-031 Per-pattern logic (pattern register, fill counter, compare, detected flop, match counter) SHALL be a sub-module seq_match_lane, instantiated NUM_PAT times in a generate loop; history register stays in the top.

Verification
REQ-032 Defaults, valid bits 0,1,1,0 -> detected=2'b01 one cycle after 4th bit, match_cnt0=1, match_cnt1=0.
REQ-033 Write pattern 1=0101, overlap_en=1, bits 0,1,0,1,0,1 -> detected[1] pulses twice, cnt1=2; repeat with overlap_en=0 -> once, cnt1=1.
REQ-034 Bits 0,1 then din_valid=0 for 3 cycles with din toggling, then 1,0 valid -> single detected[0] pulse.
REQ-035 CNT_W=2, five 0110 matches -> match_cnt0=3; clear_cnt coincident with 6th match -> match_cnt0=1.
REQ-036 Bits 0,1,1 then reset low 1 cycle, release, bit 0 -> no detection; 0,1,1,1 next -> detected=2'b10.
